// File: rtl/max_pool_ctrl.sv
// rtl/max_pool_ctrl.sv - windowed max/argmax reducer sequencing a shared float comparator
module max_pool_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int WIN           = 4,
    parameter int OUT_PER_FRAME = 16,
    localparam int IDX_W        = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] cmp_a,
    output logic [DATA_WIDTH-1:0] cmp_b,
    input  logic                  cmp_gt,
    input  logic [DATA_WIDTH-1:0] cmp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last
);

    localparam int CNT_W = $clog2(WIN + 1);
    localparam int FRM_W = $clog2(OUT_PER_FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(OUT_PER_FRAME - 1);

    typedef enum logic [1:0] {S_FIRST, S_ACC, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  accept;
    logic                  load_first;

    assign cmp_a     = in_data;
    assign cmp_b     = max_q;
    assign in_ready  = rst_n && !clear && ((state_q != S_OUT) || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        load_first  = 1'b0;

        if (clear) begin
            state_d     = S_FIRST;
            cnt_d       = '0;
            frame_cnt_d = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_FIRST: load_first = accept;
                S_ACC: begin
                    if (accept) begin
                        // Strict gt keeps the earliest maximum and never lets a NaN in
                        max_d = cmp_result;
                        if (cmp_gt) idx_d = IDX_W'(cnt_q);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            out_data_d  = cmp_result;
                            out_index_d = cmp_gt ? IDX_W'(cnt_q) : idx_q;
                            out_valid_d = 1'b1;
                            out_last_d  = (frame_cnt_q == FRM_LAST);
                            state_d     = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        frame_cnt_d = (frame_cnt_q == FRM_LAST) ? '0 : frame_cnt_q + FRM_W'(1);
                        state_d     = S_FIRST;
                        load_first  = accept;
                    end
                end
                default: state_d = S_FIRST;
            endcase

            // Shared by S_FIRST and the zero-bubble path out of S_OUT
            if (load_first) begin
                max_d = in_data;
                idx_d = '0;
                cnt_d = CNT_W'(1);
                if (WIN == 1) begin
                    out_data_d  = in_data;
                    out_index_d = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (frame_cnt_d == FRM_LAST);
                    state_d     = S_OUT;
                end else begin
                    state_d = S_ACC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FIRST;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
